// File: rtl/sdm_adc_data_aurora_recv.sv
// sdm_adc_data_aurora_recv
//   De-framer for the SDM/ADC stream arriving from the Aurora RX user interface.
//   Each incoming 64-bit word goes into a small FIFO first. An assembler then
//   hunts for a word with the frame-start flag (bit 63) set. It concatenates the
//   63-bit payloads of FRAME_WORDS consecutive words into one frame, then
//   presents the frame on DOUT together with a one-cycle DOUT_VALID strobe.
//
// Ports
//   CLK              single clock for all logic
//   RESET            asynchronous, active-low reset
//   M_AXI_RX_TDATA   Aurora RX word: [63] frame-start flag, [62:0] payload
//   M_AXI_RX_TVALID  word valid; there is no backpressure
//   DOUT             assembled frame; slot k sits at [63k+62:63k], upper bits zero
//   DOUT_VALID       one-cycle strobe in the cycle DOUT takes a new frame
//   FIFO_FULL        input FIFO occupancy == FIFO_DEPTH (registered)
module sdm_adc_data_aurora_recv #(
    parameter int NCH_ADC    = 20,
    parameter int ADC_CYC    = 20,   // informational only
    parameter int NCH_SDM    = 19,
    parameter int SDM_CYC    = 4,
    parameter int FIFO_DEPTH = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [63:0]  M_AXI_RX_TDATA,
    input  logic         M_AXI_RX_TVALID,
    output logic [511:0] DOUT,
    output logic         DOUT_VALID,
    output logic         FIFO_FULL
);

    localparam int FRAME_BITS  = NCH_ADC * 16 + NCH_SDM * 2 * SDM_CYC;
    localparam int FRAME_WORDS = (FRAME_BITS + 62) / 63;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int IW          = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_C  = IW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {HUNT, COLLECT, EMIT} state_t;

    // ---------------- input FIFO ----------------
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;
    logic          push, pop, empty;
    logic [63:0]   rd_word;

    // The full check uses the occupancy from before this edge, so a word that
    // arrives while full is dropped even if a pop happens in the same cycle.
    assign push    = M_AXI_RX_TVALID & ~full_q;
    assign empty   = (count_q == '0);
    assign rd_word = mem_q[rd_ptr_q];
    assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= M_AXI_RX_TDATA;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // ---------------- frame assembler ----------------
    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [FRAME_WORDS-1:0][62:0]  slot_q;
    logic                          slot_we;
    logic [IW-1:0]                 slot_sel;
    logic [511:0]                  dout_q;
    logic                          dvalid_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        slot_we  = 1'b0;
        slot_sel = idx_q;
        pop      = 1'b0;
        case (state_q)
            HUNT: begin
                if (!empty) begin
                    pop = 1'b1;
                    // Unflagged words here are stray or long-frame tails: drop them.
                    if (rd_word[63]) begin
                        slot_we  = 1'b1;
                        slot_sel = '0;
                        idx_d    = IW'(1);
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (!empty) begin
                    pop     = 1'b1;
                    slot_we = 1'b1;
                    if (rd_word[63]) begin
                        // A new flag means the previous frame was short. Restart from this word.
                        slot_sel = '0;
                        idx_d    = IW'(1);
                    end else if (idx_q == LAST_C) begin
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            EMIT:    state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= HUNT;
            idx_q    <= '0;
            slot_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dvalid_q <= (state_q == EMIT);
            if (slot_we) slot_q[slot_sel] <= rd_word[62:0];
            if (state_q == EMIT) dout_q <= 512'(slot_q);
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dvalid_q;
    assign FIFO_FULL  = full_q;

endmodule

// File: tb/tb_sdm_adc_data_aurora_recv.sv
// Testbench for sdm_adc_data_aurora_recv.
// The bench keeps a reference model built on queues. The model tracks the
// FIFO contents and the frame being collected. It predicts DOUT_VALID,
// FIFO_FULL and DOUT after every clock edge, using directed and random traffic.
module tb_sdm_adc_data_aurora_recv;

    localparam int FW    = 8;
    localparam int DEPTH = 32;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [63:0]  tdata = '0;
    logic         tvalid = 1'b0;
    logic [511:0] DOUT;
    logic         DOUT_VALID;
    logic         FIFO_FULL;

    sdm_adc_data_aurora_recv dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .M_AXI_RX_TDATA  (tdata),
        .M_AXI_RX_TVALID (tvalid),
        .DOUT            (DOUT),
        .DOUT_VALID      (DOUT_VALID),
        .FIFO_FULL       (FIFO_FULL)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    int n_strobe = 0, cyc_n = 0, strobe_at = 0, last_at = 0;
    bit saw_full = 0;

    // reference model state
    logic [63:0]  mq[$];
    logic [62:0]  frm[$];
    bit           in_frame, pend, m_valid, m_full;
    logic [511:0] m_dout;

    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        frm.delete();
        in_frame = 0;
        pend     = 0;
        m_valid  = 0;
        m_full   = 0;
        m_dout   = '0;
    endtask

    // Advance the model by one edge, using the inputs as they were at that edge.
    task automatic model_step();
        logic [63:0] w;
        bit push;
        push    = tvalid && (mq.size() < DEPTH);
        m_valid = 0;
        if (pend) begin
            m_dout = '0;
            for (int k = 0; k < FW; k++) m_dout[63*k +: 63] = frm[k];
            m_valid = 1;
            pend    = 0;
            frm.delete();
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            if (w[63]) begin
                frm.delete();
                frm.push_back(w[62:0]);
                in_frame = 1;
            end else if (in_frame) begin
                frm.push_back(w[62:0]);
                if (frm.size() == FW) begin
                    pend     = 1;
                    in_frame = 0;
                end
            end
        end
        if (push) mq.push_back(tdata);
        m_full = (mq.size() == DEPTH);
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        cyc_n++;
        #1;
        chk("valid", DOUT_VALID, m_valid);
        chk("full", FIFO_FULL, m_full);
        chk("dout", DOUT, m_dout);
        if (DOUT_VALID) begin
            n_strobe++;
            strobe_at = cyc_n;
        end
        if (FIFO_FULL) saw_full = 1;
    endtask

    task automatic send(logic [63:0] w);
        tdata  = w;
        tvalid = 1'b1;
        cyc();
        last_at = cyc_n;
    endtask

    task automatic idle(int n);
        tvalid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic frame(int n, logic [62:0] base);
        for (int i = 0; i < n; i++)
            send({(i == 0), base + 63'(i)});
    endtask

    initial begin
        model_reset();
        // 1. reset
        #12;
        chk("rst_dout", DOUT, '0);
        chk("rst_valid", DOUT_VALID, 0);
        chk("rst_full", FIFO_FULL, 0);
        @(negedge CLK);
        RESET = 1'b1;
        n_strobe = 0;
        idle(10);
        chk("idle_strobes", n_strobe, 0);

        // 2. clean frame
        n_strobe = 0;
        frame(FW, 63'd1);
        idle(6);
        chk("t2_strobes", n_strobe, 1);
        chk("t2_latency", strobe_at - last_at, 2);
        chk("t2_w0", DOUT[62:0], 63'd1);
        chk("t2_w7", DOUT[503:441], 63'd8);
        chk("t2_pad", DOUT[511:504], 8'd0);

        // 3. leading garbage and a long frame
        n_strobe = 0;
        for (int i = 0; i < 3; i++) send({1'b0, 63'h700 + 63'(i)});
        frame(FW + 1, 63'h100);
        idle(8);
        chk("t3_strobes", n_strobe, 1);
        chk("t3_w7", DOUT[503:441], 63'h107);

        // 4. short frame then a full frame
        n_strobe = 0;
        frame(4, 63'h200);
        frame(FW, 63'h300);
        idle(8);
        chk("t4_strobes", n_strobe, 1);
        chk("t4_w0", DOUT[62:0], 63'h300);

        // 5. overflow: continuous 9-word frames
        saw_full = 0;
        for (int f = 0; f < 50; f++) frame(FW + 1, 63'(f) << 8);
        chk("t5_full_seen", saw_full, 1);
        idle(100);
        chk("t5_full_clear", FIFO_FULL, 0);

        // 6. mid-frame reset
        frame(4, 63'h400);
        #2;
        RESET = 1'b0;
        tvalid = 1'b0;
        model_reset();
        #2;
        chk("t6_rst_valid", DOUT_VALID, 0);
        chk("t6_rst_dout", DOUT, '0);
        chk("t6_rst_full", FIFO_FULL, 0);
        @(negedge CLK);
        RESET = 1'b1;
        n_strobe = 0;
        idle(10);
        chk("t6_no_strobe", n_strobe, 0);
        frame(FW, 63'h500);
        idle(6);
        chk("t6_strobes", n_strobe, 1);
        chk("t6_w7", DOUT[503:441], 63'h507);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            r[63] = ($urandom_range(0, 6) == 0);
            tdata  = r;
            tvalid = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
